// File: rtl/eth_pkt_tx_sched.sv
// rtl/eth_pkt_tx_sched.sv - round-robin packet scheduler from two prefetch FIFOs into the UDP tx engine
// Optional per-packet header word with per-channel sequence number when ETH_PKT_HDR_EN is defined.
module eth_pkt_tx_sched #(
  parameter int PKT_WORDS = 256,
  parameter int DATA_W    = 32
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              ch0_avail,
  input  logic              ch0_rd_vld,
  input  logic [DATA_W-1:0] ch0_rd_data,
  output logic              ch0_rd_en,
  input  logic              ch1_avail,
  input  logic              ch1_rd_vld,
  input  logic [DATA_W-1:0] ch1_rd_data,
  output logic              ch1_rd_en,
  output logic              tx_start_en,
  output logic [15:0]       tx_byte_num,
  input  logic              tx_req,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic              cur_ch,
  output logic              underrun_err
);

`ifdef ETH_PKT_HDR_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif
  localparam int REQ_WORDS = PKT_WORDS + HDR_WORDS;
  localparam int CNT_W     = $clog2(REQ_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REQ_WORDS - 1);
  localparam logic [15:0]      BYTE_NUM = 16'(REQ_WORDS * 4);

  typedef enum logic [1:0] {IDLE, START, STREAM, WAIT_DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  word_cnt;
  logic              rr_pref;
  logic              grant_vld;
  logic [DATA_W-1:0] grant_data;
  logic              take_req;
  logic              is_hdr;
  logic              pop;
  logic [15:0]       cur_seq;
  logic [DATA_W-1:0] hdr_word;

  assign tx_byte_num = BYTE_NUM;
  assign grant_vld   = cur_ch ? ch1_rd_vld  : ch0_rd_vld;
  assign grant_data  = cur_ch ? ch1_rd_data : ch0_rd_data;

  // A request coinciding with reset or a premature done must not pop a word we would then drop.
  assign take_req  = (state == STREAM) && tx_req && !tx_done && !rd_rst;
  assign pop       = take_req && !is_hdr && grant_vld;
  assign ch0_rd_en = pop && !cur_ch;
  assign ch1_rd_en = pop && cur_ch;
  assign hdr_word  = DATA_W'({cur_ch, 7'd0, 8'd0, cur_seq});

`ifdef ETH_PKT_HDR_EN
  logic [15:0] seq0;
  logic [15:0] seq1;
  assign is_hdr  = (word_cnt == '0);
  assign cur_seq = cur_ch ? seq1 : seq0;
`else
  assign is_hdr  = 1'b0;
  assign cur_seq = 16'd0;
`endif

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      cur_ch       <= 1'b0;
      rr_pref      <= 1'b0;
      tx_start_en  <= 1'b0;
      tx_data      <= '0;
      underrun_err <= 1'b0;
      word_cnt     <= '0;
`ifdef ETH_PKT_HDR_EN
      seq0         <= 16'd0;
      seq1         <= 16'd0;
`endif
    end else begin
      tx_start_en <= 1'b0;
      case (state)
        IDLE: begin
          if (ch0_avail || ch1_avail) begin
            cur_ch <= (ch0_avail && ch1_avail) ? rr_pref : ch1_avail;
            state  <= START;
            busy   <= 1'b1;
          end
        end
        START: begin
          tx_start_en <= 1'b1;
          word_cnt    <= '0;
          state       <= STREAM;
        end
        STREAM: begin
          if (tx_done) begin
            underrun_err <= 1'b1;
            state        <= IDLE;
            busy         <= 1'b0;
          end else if (tx_req) begin
            word_cnt <= word_cnt + CNT_W'(1);
            if (word_cnt == CNT_LAST)
              state <= WAIT_DONE;
            if (is_hdr) begin
              tx_data <= hdr_word;
            end else if (grant_vld) begin
              tx_data <= grant_data;
            end else begin
              tx_data      <= '0;
              underrun_err <= 1'b1;
            end
          end
        end
        WAIT_DONE: begin
          // Pointer favours the other channel next time both are ready.
          if (tx_done) begin
            rr_pref <= ~cur_ch;
            state   <= IDLE;
            busy    <= 1'b0;
`ifdef ETH_PKT_HDR_EN
            if (cur_ch)
              seq1 <= seq1 + 16'd1;
            else
              seq0 <= seq0 + 16'd1;
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_pkt_tx_sched.sv
// tb/tb_eth_pkt_tx_sched.sv - scoreboard bench for eth_pkt_tx_sched with FIFO and engine models
// Reference model predicts grant, payload words and pop counts from queue contents.
module tb_eth_pkt_tx_sched;
  localparam int PKT_WORDS = 4;
`ifdef ETH_PKT_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int REQ   = PKT_WORDS + HDR;
  localparam int BYTES = REQ * 4;

  logic        clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic        ch0_avail = 1'b0, ch1_avail = 1'b0;
  logic        ch0_rd_vld, ch1_rd_vld, ch0_rd_en, ch1_rd_en;
  logic [31:0] ch0_rd_data, ch1_rd_data, tx_data;
  logic        tx_start_en, tx_req = 1'b0, tx_done = 1'b0;
  logic [15:0] tx_byte_num;
  logic        busy, cur_ch, underrun_err;

  logic [31:0] mem [0:1][0:1023];
  int          wp [2];
  int          rp [2];
  bit          nv [2];

  int          vectors = 0, miscompares = 0;
  int          start_q[$];
  logic [31:0] data_q[$];
  bit          mute = 1'b0;
  bit          pref = 1'b0;
  bit          exp_under = 1'b0;
  logic [15:0] seq [2];
  logic [31:0] last_tx = 32'd0;

  eth_pkt_tx_sched #(.PKT_WORDS(PKT_WORDS), .DATA_W(32)) dut (
    .rd_clk(clk), .rd_rst(rd_rst),
    .ch0_avail(ch0_avail), .ch0_rd_vld(ch0_rd_vld), .ch0_rd_data(ch0_rd_data), .ch0_rd_en(ch0_rd_en),
    .ch1_avail(ch1_avail), .ch1_rd_vld(ch1_rd_vld), .ch1_rd_data(ch1_rd_data), .ch1_rd_en(ch1_rd_en),
    .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num), .tx_req(tx_req), .tx_data(tx_data),
    .tx_done(tx_done), .busy(busy), .cur_ch(cur_ch), .underrun_err(underrun_err)
  );

  always #5 clk = ~clk;

  assign ch0_rd_vld  = (rp[0] < wp[0]) && !nv[0];
  assign ch1_rd_vld  = (rp[1] < wp[1]) && !nv[1];
  assign ch0_rd_data = mem[0][rp[0]];
  assign ch1_rd_data = mem[1][rp[1]];

  always @(posedge clk) begin
    if (ch0_rd_en) rp[0] <= rp[0] + 1;
    if (ch1_rd_en) rp[1] <= rp[1] + 1;
  end

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endfunction

  function automatic void fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s", nm);
  endfunction

  // Monitor: one-hot pops, start records and payload words as the DUT presents them.
  initial begin
    bit due = 1'b0;
    int sc;
    forever begin
      @(negedge clk);
      if (rd_rst) begin
        due = 1'b0;
      end else begin
        check("rd_en_exclusive", {31'd0, ch0_rd_en & ch1_rd_en}, 32'd0);
        if (tx_start_en) begin
          if (start_q.size() == 0) fail("unexpected_tx_start");
          else begin
            sc = start_q.pop_front();
            check("start_cur_ch", {31'd0, cur_ch}, sc);
            check("start_byte_num", {16'd0, tx_byte_num}, BYTES);
          end
        end
        if (due && !mute) begin
          if (data_q.size() == 0) fail("unexpected_tx_data");
          else check("tx_data", tx_data, data_q.pop_front());
        end
        due = tx_req;
      end
    end
  end

  task automatic fill(input int c);
    while (wp[c] - rp[c] < PKT_WORDS) begin
      mem[c][wp[c]] = $urandom;
      wp[c]++;
    end
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!tx_start_en && lat < 20);
  endtask

  task automatic model_reset();
    pref = 1'b0; exp_under = 1'b0; last_tx = 32'd0;
    seq[0] = 16'd0; seq[1] = 16'd0;
  endtask

  task automatic do_reset();
    rd_rst = 1'b1; tx_req = 1'b0; tx_done = 1'b0; ch0_avail = 1'b0; ch1_avail = 1'b0;
    repeat (2) @(posedge clk);
    #1 rd_rst = 1'b0;
    model_reset();
  endtask

  task automatic run_pkt(input bit a0, input bit a1, input int drop, input int extra,
                         input int early, input bit keep, input bit chk_lat);
    int ch, lat, n, k, s0, s1, exp_pops;
    logic [31:0] e;
    if (a0) fill(0);
    if (a1) fill(1);
    ch = (a0 && a1) ? int'(pref) : (a1 ? 1 : 0);
    start_q.push_back(ch);
    s0 = rp[0]; s1 = rp[1]; k = rp[ch];
    ch0_avail = a0; ch1_avail = a1;
    wait_start(lat);
    if (!tx_start_en) begin
      fail("tx_start_timeout");
      start_q.delete();
      ch0_avail = 1'b0; ch1_avail = 1'b0;
      @(posedge clk); #1;
      return;
    end
    if (chk_lat) check("start_latency", lat - 1, 2);
    if (!keep) begin ch0_avail = 1'b0; ch1_avail = 1'b0; end
    @(posedge clk); #1;
    n = (early > 0) ? early : REQ + extra;
    for (int i = 0; i < n; i++) begin
      tx_req = 1'b1;
      if (i < REQ) begin
        if (HDR == 1 && i == 0) e = {ch[0], 15'd0, seq[ch]};
        else if (i - HDR == drop) begin e = 32'd0; nv[ch] = 1'b1; exp_under = 1'b1; end
        else begin e = mem[ch][k]; k++; end
        last_tx = e;
      end else begin
        e = last_tx;
      end
      data_q.push_back(e);
      @(posedge clk); #1;
      nv[0] = 1'b0; nv[1] = 1'b0;
    end
    tx_req = 1'b0;
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    if (early == 0) begin
      pref = !ch[0];
      seq[ch] = seq[ch] + 16'd1;
    end else begin
      exp_under = 1'b1;
    end
    exp_pops = k - ((ch == 1) ? s1 : s0);
    check("pops_ch0", rp[0] - s0, (ch == 0) ? exp_pops : 0);
    check("pops_ch1", rp[1] - s1, (ch == 1) ? exp_pops : 0);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("underrun_err", {31'd0, underrun_err}, {31'd0, exp_under});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    int lat, s0, dr;
    bit r0, r1;
    do_reset();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_start_en", {31'd0, tx_start_en}, 32'd0);
    check("rst_rd_en", {30'd0, ch1_rd_en, ch0_rd_en}, 32'd0);
    check("rst_underrun", {31'd0, underrun_err}, 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    check("rst_cur_ch", {31'd0, cur_ch}, 32'd0);
    check("rst_byte_num", {16'd0, tx_byte_num}, BYTES);

    for (int i = 0; i < PKT_WORDS; i++) begin
      mem[0][wp[0]] = 32'h11 + i;
      wp[0]++;
    end
    run_pkt(1, 0, -1, 0, 0, 0, 1);

    do_reset();
    run_pkt(1, 1, -1, 0, 0, 1, 1);
    run_pkt(1, 1, -1, 0, 0, 1, 0);
    run_pkt(1, 1, -1, 0, 0, 0, 0);

    run_pkt(1, 0, 2, 0, 0, 0, 1);
    run_pkt(0, 1, -1, 0, 0, 0, 1);
    run_pkt(0, 1, -1, 2, 0, 0, 1);

    do_reset();
    for (int p = 0; p < 25; p++) begin
      r0 = 1'($urandom_range(1));
      r1 = 1'($urandom_range(1));
      if (!r0 && !r1) r0 = 1'b1;
      dr = ($urandom_range(3) == 0) ? int'($urandom_range(PKT_WORDS - 1)) : -1;
      run_pkt(r0, r1, dr, int'($urandom_range(2)), 0, 0, 1);
    end

    run_pkt(1, 0, -1, 0, 2, 0, 1);

    // Reset in the middle of a packet
    fill(0);
    start_q.push_back(0);
    s0 = rp[0];
    ch0_avail = 1'b1;
    wait_start(lat);
    if (!tx_start_en) fail("tx_start_timeout_rst");
    ch0_avail = 1'b0;
    @(posedge clk); #1;
    mute = 1'b1;
    repeat (2) begin
      tx_req = 1'b1;
      @(posedge clk); #1;
    end
    rd_rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_rd_en", {30'd0, ch1_rd_en, ch0_rd_en}, 32'd0);
    check("midrst_underrun", {31'd0, underrun_err}, 32'd0);
    check("midrst_cur_ch", {31'd0, cur_ch}, 32'd0);
    check("midrst_tx_data", tx_data, 32'd0);
    check("midrst_pops", rp[0] - s0, 2 - HDR);
    rd_rst = 1'b0; tx_req = 1'b0;
    @(posedge clk); #1;
    data_q.delete();
    start_q.delete();
    mute = 1'b0;
    model_reset();

    run_pkt(0, 1, -1, 0, 0, 0, 1);
    run_pkt(0, 1, -1, 0, 0, 0, 1);

    repeat (3) @(posedge clk);
    check("data_q_drained", data_q.size(), 0);
    check("start_q_drained", start_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
